// File: rtl/mul_wt_pipe.sv
// mul_wt_pipe -- pipelined W x W multiplier built from a carry-save
// compressor tree (rows of 3:2 full adders, level by level, down to two
// rows) and a final 2W-bit carry-propagate adder.
//
// Optional feature macro: MUL_WT_SIGNED_EN
//   defined   : per-op two's-complement mode (tc) using modified Baugh-Wooley;
//               tc travels with each op so signed/unsigned may interleave.
//   undefined : tc is ignored, every op is unsigned, no tc flops exist.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready = !out_valid || out_ready)
//   a, b                W-bit operands
//   tc                  two's-complement select (signed build only)
//   in_tag              opaque tag carried with the op
//   out_valid/out_ready result handshake
//   result              2W-bit exact product
//   out_tag             tag of the op currently on result
//
// Parameters: W (4..32), STAGES (1..4, = latency), TAG_W (>=1).
module mul_wt_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic               tc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     result,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int W2 = 2 * W;

  // Carry-save state: up to W rows of 2W bits. Rows past the live count are 0.
  typedef logic [W-1:0][W2-1:0] rows_t;

  // Row count after one 3:2 level: each group of three becomes two.
  function automatic int rows_after(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Live rows entering reduction level s.
  function automatic int rows_at(input int s);
    int n;
    n = W;
    for (int i = 0; i < s; i++) n = rows_after(n);
    return n;
  endfunction

  function automatic int calc_levels();
    int n, l;
    n = W;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 2) begin
        n = rows_after(n);
        l++;
      end
    end
    return l;
  endfunction

  localparam int NLEV  = calc_levels();
  localparam int NSTEP = NLEV + 1;  // reduction levels plus the final adder

  // One level of row-wise 3:2 compression. Leftover rows (n mod 3) pass
  // through untouched; carries shift left and the bit leaving column 2W-1
  // is dropped, which is harmless because the product is taken mod 2^2W.
  function automatic rows_t csa_level(input rows_t x, input int n);
    rows_t y;
    int    o;
    y = '0;
    o = 0;
    for (int g = 0; g < W / 3; g++) begin
      if (3 * g + 2 < n) begin
        y[o]     = x[3*g] ^ x[3*g+1] ^ x[3*g+2];
        y[o+1]   = ((x[3*g] & x[3*g+1]) | (x[3*g] & x[3*g+2]) |
                    (x[3*g+1] & x[3*g+2])) << 1;
        o += 2;
      end
    end
    for (int i = 0; i < W; i++) begin
      if (i >= 3 * (n / 3) && i < n) begin
        y[o] = x[i];
        o++;
      end
    end
    return y;
  endfunction

  // Step s < NLEV is a compression level; step NLEV is the final CPA.
  // The Baugh-Wooley constant at column 2W-1 is applied here: adding 2^(2W-1)
  // modulo 2^2W is just a flip of the MSB, gated by this stage's tc.
  function automatic rows_t do_step(input rows_t x, input int s, input logic t);
    rows_t y;
    y = '0;
    if (s < NLEV) begin
      y = csa_level(x, rows_at(s));
    end else begin
      y[0] = (x[0] + x[1]) ^ {t, {(W2-1){1'b0}}};
    end
    return y;
  endfunction

  logic w_tc_in;

`ifdef MUL_WT_SIGNED_EN
  localparam bit SGN = 1'b1;
  assign w_tc_in = tc;
`else
  localparam bit SGN = 1'b0;
  logic w_unused_tc;
  assign w_unused_tc = tc;
  assign w_tc_in     = 1'b0;
`endif

  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Partial products. In signed mode terms with exactly one operand MSB are
  // inverted, and the column-W constant rides in row 0's free bit W.
  rows_t w_pp;
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < W; j++) begin
      for (int i = 0; i < W; i++) begin
        w_pp[j][i+j] = (a[i] & b[j]) ^ (w_tc_in & ((i == W-1) != (j == W-1)));
      end
    end
    w_pp[0][W] = w_tc_in;
  end

  // Inputs to each rank's combinational segment.
  rows_t              w_src_rows [STAGES];
  logic [STAGES-1:0]  w_src_vld;
  logic [STAGES-1:0]  w_src_tc;
  logic [TAG_W-1:0]   w_src_tag  [STAGES];

  assign w_src_rows[0] = w_pp;
  assign w_src_vld[0]  = in_valid;
  assign w_src_tc[0]   = w_tc_in;
  assign w_src_tag[0]  = in_tag;

  // Rank r evaluates steps S0..S1 then registers. Steps are divided evenly;
  // the last rank always finishes with the final adder.
  for (genvar r = 0; r < STAGES; r++) begin : g_rank
    localparam int S0 = (r * NSTEP) / STAGES;
    localparam int S1 = ((r + 1) * NSTEP) / STAGES - 1;

    rows_t w_seg;
    always_comb begin
      w_seg = w_src_rows[r];
      for (int s = S0; s <= S1; s++) w_seg = do_step(w_seg, s, w_src_tc[r]);
    end

    if (r < STAGES - 1) begin : g_mid
      rows_t              r_rows;
      logic               r_vld;
      logic [TAG_W-1:0]   r_tag;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rows <= '0;
          r_vld  <= 1'b0;
          r_tag  <= '0;
        end else if (w_adv) begin
          r_rows <= w_seg;
          r_vld  <= w_src_vld[r];
          r_tag  <= w_src_tag[r];
        end
      end

      assign w_src_rows[r+1] = r_rows;
      assign w_src_vld[r+1]  = r_vld;
      assign w_src_tag[r+1]  = r_tag;

      if (SGN) begin : g_tc
        logic r_tc;
        always_ff @(posedge clk) begin
          if (rst)        r_tc <= 1'b0;
          else if (w_adv) r_tc <= w_src_tc[r];
        end
        assign w_src_tc[r+1] = r_tc;
      end else begin : g_notc
        assign w_src_tc[r+1] = 1'b0;
      end
    end else begin : g_last
      logic [W2-1:0]    r_res;
      logic             r_vld;
      logic [TAG_W-1:0] r_tag;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_res <= '0;
          r_vld <= 1'b0;
          r_tag <= '0;
        end else if (w_adv) begin
          r_res <= w_seg[0];
          r_vld <= w_src_vld[r];
          r_tag <= w_src_tag[r];
        end
      end

      assign result    = r_res;
      assign out_valid = r_vld;
      assign out_tag   = r_tag;
    end
  end

endmodule
